param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter AF_THRESH, default DEPTH-4, almost_full asserts at count >= AF_THRESH; legal range 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts at count <= AE_THRESH; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all logic updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 w_en  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 r_en  input  1  read request.
REQ-011 clr_err  input  1  synchronous clear of the overflow and underflow flags.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= AF_THRESH.
REQ-016 almost_empty  output  1  count <= AE_THRESH.
REQ-017 count  output  $clog2(DEPTH)+1  number of stored words.
REQ-018 overflow  output  1  sticky; a write was dropped.
REQ-019 underflow  output  1  sticky; a read was rejected.

Function
REQ-020 Write accepted = w_en && (!full || read accepted in the same cycle); the accepted word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-021 Read accepted = r_en && !empty; rd_ptr increments modulo DEPTH.
REQ-022 Simultaneous accepted read and write: count is unchanged; when full, both are accepted; when empty, only the write is accepted and underflow sets.
REQ-023 Count rule: count_next = count + wr_acc - rd_acc; never exceeds DEPTH and never drops below 0.
REQ-024 full, empty, almost_full and almost_empty are registered and derived from count_next, so they always agree with count in the same cycle.
REQ-025 FWFT=0: data_out loads mem[rd_ptr] on the edge that accepts a read (1-cycle latency) and holds its value otherwise.
REQ-026 FWFT=1: data_out shows the head word whenever !empty, with no read required; a word written into an empty FIFO appears on data_out the cycle after the write edge; an accepted read advances data_out to the next word in the same manner; data_out holds its last value while empty.
REQ-027 w_en && !wr_acc sets overflow; the word is discarded and pointers and count are unchanged.
REQ-028 r_en && !rd_acc sets underflow; pointers, count and data_out are unchanged.
REQ-029 clr_err=1 clears overflow and underflow; a new error event in the same cycle takes priority and leaves the flag set.
REQ-030 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no bubble; stored order is preserved across the wrap.

Reset
REQ-031 rst_n=0 sampled at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-032 Reset has priority over all other inputs; any write or read in progress is abandoned.
REQ-033 Memory contents are not reset and are never visible after reset until rewritten.
REQ-034 The first write may be accepted on the first edge with rst_n=1.

Verification
REQ-035 DEPTH=16, DATA_WIDTH=8: write 0x00..0x0F, then 1 more write -> full=1 after 16 writes, count=16, overflow=1, 17th word dropped; read 16 -> data 0x00..0x0F in order, empty=1.
REQ-036 Thresholds AF_THRESH=12, AE_THRESH=2: almost_empty clears on the edge that makes count=3; almost_full sets on the edge that makes count=12; both flags toggle back when draining.
REQ-037 Full FIFO, w_en=r_en=1 for 40 cycles with an incrementing pattern -> count stays 16, no overflow, output order is exact across several pointer wraps.
REQ-038 Empty FIFO, r_en=1 -> underflow=1 and data_out unchanged; then clr_err=1 for one cycle -> underflow=0.
REQ-039 FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 on the next cycle without r_en; r_en=1 -> empty=1, data_out holds 0xA5.
REQ-040 Mid-stream reset after 7 writes: rst_n=0 for 1 edge -> count=0, empty=1, overflow=0, data_out=0; the next write/read pair returns the new word.

Source files
------------

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// param_sync_fifo : single-clock FIFO, registered or first-word-fall-through read
// Revision: 1.0
// ============================================================================
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       r_en,
  input  logic                       clr_err,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [c_CNT_W-1:0]    w_count_next;
  logic [c_PTR_W-1:0]    w_rd_ptr_inc;
  logic [c_PTR_W-1:0]    w_wr_ptr_inc;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign w_rd_acc     = r_en && !empty;
  assign w_wr_acc     = w_en && (!full || w_rd_acc);
  assign w_count_next = count + c_CNT_W'(w_wr_acc) - c_CNT_W'(w_rd_acc);
  assign w_rd_ptr_inc = r_rd_ptr + c_PTR_W'(1);
  assign w_wr_ptr_inc = r_wr_ptr + c_PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
      count        <= w_count_next;
      full         <= (w_count_next == c_CNT_W'(DEPTH));
      empty        <= (w_count_next == '0);
      almost_full  <= (w_count_next >= c_CNT_W'(AF_THRESH));
      almost_empty <= (w_count_next <= c_CNT_W'(AE_THRESH));
      // A new error event wins over a clear in the same cycle.
      if (w_en && !w_wr_acc)  overflow  <= 1'b1;
      else if (clr_err)       overflow  <= 1'b0;
      if (r_en && !w_rd_acc)  underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is kept in data_out; the next head comes from memory or,
      // when the FIFO holds a single word, from the write bypass.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out <= '0;
        end else if (w_rd_acc) begin
          if (count > c_CNT_W'(1)) data_out <= r_mem[w_rd_ptr_inc];
          else if (w_wr_acc)       data_out <= data_in;
        end else if (w_wr_acc && empty) begin
          data_out <= data_in;
        end
      end
    end else begin : g_reg_read
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out <= '0;
        end else if (w_rd_acc) begin
          data_out <= r_mem[r_rd_ptr];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_param_sync_fifo : directed checks of param_sync_fifo, registered and FWFT
// Revision: 1.0
// ============================================================================
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en, r_en, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_w_en, f_r_en, f_clr_err;
  logic [7:0] f_data_in;
  logic [7:0] f_data_out;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
    .clr_err(f_clr_err), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    f_w_en = 1'b0; f_r_en = 1'b0; f_clr_err = 1'b0; f_data_in = 8'h00;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", data_out, 0);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, watching the threshold flags on every edge.
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_ae", almost_empty, ((i + 1) <= 2) ? 1 : 0);
      chk("fill_af", almost_full, ((i + 1) >= 12) ? 1 : 0);
      chk("fill_full", full, (i == 15) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    data_in = 8'hFF;
    tick();
    w_en = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);

    // Error event beats clear; then a lone clear drops the flag.
    w_en = 1'b1; clr_err = 1'b1;
    tick();
    chk("clr_prio_ovf", overflow, 1);
    w_en = 1'b0;
    tick();
    chk("clr_ovf", overflow, 0);
    clr_err = 1'b0;

    for (int i = 0; i < 16; i++) begin
      r_en = 1'b1;
      tick();
      chk("drain_data", data_out, i);
      chk("drain_count", count, 15 - i);
      chk("drain_ae", almost_empty, ((15 - i) <= 2) ? 1 : 0);
      chk("drain_af", almost_full, ((15 - i) >= 12) ? 1 : 0);
      chk("drain_empty", empty, (i == 15) ? 1 : 0);
    end

    tick();
    r_en = 1'b0;
    chk("unf_flag", underflow, 1);
    chk("unf_dout", data_out, 8'h0F);
    chk("unf_count", count, 0);
    tick();
    chk("unf_sticky", underflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clr", underflow, 0);

    // Empty with read and write together: only the write lands.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
    tick();
    chk("ewr_count", count, 1);
    chk("ewr_unf", underflow, 1);
    chk("ewr_dout", data_out, 8'h0F);
    w_en = 1'b0; clr_err = 1'b1;
    tick();
    r_en = 1'b0; clr_err = 1'b0;
    chk("ewr_read", data_out, 8'h77);
    chk("ewr_count0", count, 0);
    chk("ewr_unf_clr", underflow, 0);

    // Full FIFO streaming through several pointer wraps.
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; data_in = 8'(8'h20 + i);
      tick();
    end
    chk("stream_full0", full, 1);
    r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      data_in = 8'(8'h30 + k);
      tick();
      chk("stream_data", data_out, (k < 16) ? (8'h20 + k) : (8'h30 + k - 16));
      chk("stream_count", count, 16);
      chk("stream_ovf", overflow, 0);
    end
    w_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("stream_drain", data_out, 8'h48 + k);
    end
    r_en = 1'b0;
    chk("stream_empty", empty, 1);

    // Mid-stream reset, with a write request present on the reset edge.
    for (int i = 0; i < 7; i++) begin
      w_en = 1'b1; data_in = 8'(8'h50 + i);
      tick();
    end
    chk("mid_count7", count, 7);
    rst_n = 1'b0; data_in = 8'hEE;
    tick();
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_dout", data_out, 0);
    chk("mid_ae", almost_empty, 1);
    rst_n = 1'b1; data_in = 8'hC3;
    tick();
    chk("post_count", count, 1);
    w_en = 1'b0; r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("post_data", data_out, 8'hC3);
    chk("post_empty", empty, 1);

    // First-word-fall-through instance.
    chk("f_empty0", f_empty, 1);
    chk("f_dout0", f_data_out, 0);
    f_w_en = 1'b1; f_data_in = 8'hA5;
    tick();
    f_w_en = 1'b0;
    chk("f_a5", f_data_out, 8'hA5);
    chk("f_count1", f_count, 1);
    tick();
    chk("f_a5_hold", f_data_out, 8'hA5);
    f_r_en = 1'b1;
    tick();
    f_r_en = 1'b0;
    chk("f_rd_empty", f_empty, 1);
    chk("f_rd_hold", f_data_out, 8'hA5);

    f_w_en = 1'b1; f_data_in = 8'h01;
    tick();
    chk("f_head1", f_data_out, 8'h01);
    f_data_in = 8'h02;
    tick();
    f_data_in = 8'h03;
    tick();
    f_w_en = 1'b0;
    chk("f_head1b", f_data_out, 8'h01);
    chk("f_count3", f_count, 3);
    f_r_en = 1'b1;
    tick();
    chk("f_head2", f_data_out, 8'h02);
    tick();
    chk("f_head3", f_data_out, 8'h03);
    f_w_en = 1'b1; f_data_in = 8'h22;
    tick();
    f_w_en = 1'b0;
    chk("f_bypass", f_data_out, 8'h22);
    chk("f_bypass_cnt", f_count, 1);
    tick();
    f_r_en = 1'b0;
    chk("f_last_empty", f_empty, 1);
    chk("f_last_hold", f_data_out, 8'h22);
    chk("f_no_unf", f_underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
